clq_lookup_arb: RTL and testbench
=================================

Name: clq_lookup_arb

Overview:
- Shares the single unit-clause lookup port of the clause queue (CLQ) between NUM_REQ BCP engines.
- Waits for the clause arbiter to finish loading the dummy-head table, then accepts unit-literal requests round-robin.
- Drives one CLQ lookup at a time, registers the returned init pointer, and returns it to the winning engine with a valid/ready handshake.

Parameters:
NUM_REQ, 4, number of BCP engines sharing the lookup port
LIT_W, 8, literal width; MSB is polarity (1 = negative), two's-complement encoding
PTR_W, 4, CLQ node-pointer width (log2 of CLQ depth)

Ports:
clk  in  1  clock
rst_n  in  1  reset, synchronous, active-high (asserted = 1)
dummies_loaded  in  1  pulse: dummy-head table has been written into CLQ
flush  in  1  pulse: abandon the current problem and return to waiting for load
req_valid  in  NUM_REQ  per-engine lookup request
req_lit  in  NUM_REQ*LIT_W  per-engine literal; engine i uses bits [i*LIT_W +: LIT_W]
req_ready  out  NUM_REQ  one-hot accept
clq_rqst_lit  out  LIT_W  literal presented to CLQ
clq_rqst_valid  out  1  CLQ lookup strobe
clq_init_ptr  in  PTR_W  CLQ combinational result
clq_init_ptr_valid  in  1  CLQ hit (0 = literal has no clauses)
resp_valid  out  NUM_REQ  one-hot response valid
resp_ready  in  NUM_REQ  per-engine response accept
resp_hit  out  1  response: clause list exists
resp_ptr  out  PTR_W  response: head pointer (0 when resp_hit = 0)
busy  out  1  FSM not in IDLE or WAIT_LOAD
lookup_cnt  out  16  number of CLQ lookups issued, saturating

Behaviour:
- Reset: FSM = WAIT_LOAD, rr_last = NUM_REQ-1, lookup_cnt = 0.
- Reset values of outputs: req_ready = 0, resp_valid = 0, clq_rqst_valid = 0, clq_rqst_lit = 0, resp_hit = 0, resp_ptr = 0, busy = 0.
- All outputs are registered or decoded from FSM/latched state only. No combinational path from req_* to clq_*.
- WAIT_LOAD:
  - req_ready = 0.
  - dummies_loaded = 1 -> IDLE next cycle.
- IDLE:
  - If any req_valid, pick the winner round-robin, scanning from rr_last+1 with wrap mod NUM_REQ.
  - req_ready[winner] = 1 combinationally in the same cycle; that is the accept.
  - On accept, latch the literal and the winner id, and set rr_last = winner.
  - Literal == 0 (invalid): go to RESP with hit = 0, ptr = 0; no CLQ lookup, no counter increment.
  - Any other literal: go to LOOKUP.
- LOOKUP (exactly 1 cycle):
  - clq_rqst_valid = 1, clq_rqst_lit = latched literal.
  - At the clock edge, capture resp_hit = clq_init_ptr_valid and resp_ptr = clq_init_ptr when the hit is set, else 0.
  - lookup_cnt += 1, saturating at 0xFFFF.
  - Go to RESP.
- RESP:
  - resp_valid[winner] = 1; resp_hit and resp_ptr held stable.
  - Stays in RESP until resp_ready[winner] = 1, then returns to IDLE next cycle.
  - resp_ready on non-winner bits is ignored.
- Latency:
  - Accept to resp_valid = 2 cycles; invalid literal = 1 cycle.
  - Minimum request spacing is 3 cycles per lookup.
- flush has highest priority in every state:
  - Next state = WAIT_LOAD; lookup_cnt cleared; any in-flight response dropped (resp_valid deasserts next cycle).
  - rr_last is kept.
- dummies_loaded outside WAIT_LOAD is ignored.
- rst_n asserted mid-operation behaves exactly like power-on reset, with the same values as above.
- Requests are never lost silently: a non-accepted engine must hold req_valid and req_lit.

Test Plan:
- Reset, then all four req_valid = 1 before dummies_loaded -> req_ready stays 0. Pulse dummies_loaded -> engine 0 accepted on the first IDLE cycle.
- Engines 0..3 requesting continuously -> grant order 0,1,2,3,0, with accepts 3 cycles apart when resp_ready is tied high.
- Engine 2 requests lit 0x05, CLQ returns ptr 0x7, valid 1 -> clq_rqst_lit = 0x05 for one cycle; resp_valid = 0b0100, hit = 1, ptr = 0x7; lookup_cnt = 1.
- Engine 1 requests lit 0xFD (-3), CLQ returns valid 0 with ptr 0xA -> resp hit = 0, ptr = 0. Request lit 0x00 -> resp hit = 0 after 1 cycle, clq_rqst_valid never asserted.
- Hold resp_ready = 0 for 5 cycles -> resp_valid and data held, no new req_ready. Assert flush during RESP -> resp_valid drops, FSM back in WAIT_LOAD, lookup_cnt = 0.
- Force lookup_cnt to 0xFFFF via 65535 lookups (or a bench backdoor) -> one more lookup leaves it at 0xFFFF.

Source files
------------

// File: rtl/clq_lookup_arb.sv
`default_nettype none
// ============================================================================
// Module   : clq_lookup_arb
// Brief    : Round-robin arbiter that shares the CLQ unit-clause lookup port
//            between NUM_REQ BCP engines, one lookup at a time.
// Revision : 1.0 - initial release
// ============================================================================
module clq_lookup_arb #(
    parameter int NUM_REQ = 4,
    parameter int LIT_W   = 8,
    parameter int PTR_W   = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     dummies_loaded,
    input  logic                     flush,
    input  logic [NUM_REQ-1:0]       req_valid,
    input  logic [NUM_REQ*LIT_W-1:0] req_lit,
    output logic [NUM_REQ-1:0]       req_ready,
    output logic [LIT_W-1:0]         clq_rqst_lit,
    output logic                     clq_rqst_valid,
    input  logic [PTR_W-1:0]         clq_init_ptr,
    input  logic                     clq_init_ptr_valid,
    output logic [NUM_REQ-1:0]       resp_valid,
    input  logic [NUM_REQ-1:0]       resp_ready,
    output logic                     resp_hit,
    output logic [PTR_W-1:0]         resp_ptr,
    output logic                     busy,
    output logic [15:0]              lookup_cnt
);

    localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    localparam logic [1:0] c_WAIT_LOAD = 2'd0;
    localparam logic [1:0] c_IDLE      = 2'd1;
    localparam logic [1:0] c_LOOKUP    = 2'd2;
    localparam logic [1:0] c_RESP      = 2'd3;

    localparam logic [15:0] c_CNT_MAX = 16'hFFFF;

    logic [1:0]         r_state;
    logic [1:0]         w_state_nxt;
    logic [ID_W-1:0]    r_rr_last;
    logic [ID_W-1:0]    r_win;
    logic [ID_W-1:0]    w_win;
    logic [ID_W-1:0]    w_idx;
    logic               w_found;
    logic               w_accept;
    logic [LIT_W-1:0]   w_lit_sel;
    logic [LIT_W-1:0]   r_lit;
    logic               r_hit;
    logic [PTR_W-1:0]   r_ptr;
    logic [15:0]        r_lookup_cnt;

    // Scan starts one past the last winner so every engine gets a turn.
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        w_idx   = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            w_idx = ID_W'((int'(r_rr_last) + i) % NUM_REQ);
            if (!w_found && req_valid[w_idx]) begin
                w_found = 1'b1;
                w_win   = w_idx;
            end
        end
    end

    assign w_accept  = (r_state == c_IDLE) && w_found && !flush;
    assign w_lit_sel = req_lit[w_win*LIT_W +: LIT_W];
    assign req_ready = w_accept ? (NUM_REQ'(1) << w_win) : '0;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_WAIT_LOAD: if (dummies_loaded) w_state_nxt = c_IDLE;
            c_IDLE:      if (w_accept) w_state_nxt = (w_lit_sel == '0) ? c_RESP : c_LOOKUP;
            c_LOOKUP:    w_state_nxt = c_RESP;
            c_RESP:      if (resp_ready[r_win]) w_state_nxt = c_IDLE;
            default:     w_state_nxt = c_WAIT_LOAD;
        endcase
        if (flush) w_state_nxt = c_WAIT_LOAD;
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            r_state      <= c_WAIT_LOAD;
            r_rr_last    <= ID_W'(NUM_REQ - 1);
            r_win        <= '0;
            r_lit        <= '0;
            r_hit        <= 1'b0;
            r_ptr        <= '0;
            r_lookup_cnt <= '0;
        end else begin
            r_state <= w_state_nxt;
            // A zero literal skips the lookup, so the miss result is preloaded here.
            if (w_accept) begin
                r_win     <= w_win;
                r_rr_last <= w_win;
                r_lit     <= w_lit_sel;
                r_hit     <= 1'b0;
                r_ptr     <= '0;
            end
            if (r_state == c_LOOKUP && !flush) begin
                r_hit <= clq_init_ptr_valid;
                r_ptr <= clq_init_ptr_valid ? clq_init_ptr : '0;
            end
            if (flush)
                r_lookup_cnt <= '0;
            else if (r_state == c_LOOKUP && r_lookup_cnt != c_CNT_MAX)
                r_lookup_cnt <= r_lookup_cnt + 16'd1;
        end
    end

    assign clq_rqst_valid = (r_state == c_LOOKUP);
    assign clq_rqst_lit   = clq_rqst_valid ? r_lit : '0;
    assign resp_valid     = (r_state == c_RESP) ? (NUM_REQ'(1) << r_win) : '0;
    assign resp_hit       = r_hit;
    assign resp_ptr       = r_ptr;
    assign busy           = (r_state == c_LOOKUP) || (r_state == c_RESP);
    assign lookup_cnt     = r_lookup_cnt;

endmodule
`default_nettype wire

// File: tb/tb_clq_lookup_arb.sv
`default_nettype none
// ============================================================================
// Module   : tb_clq_lookup_arb
// Brief    : Directed, table-driven self-checking bench for clq_lookup_arb.
// Revision : 1.0 - initial release
// ============================================================================
module tb_clq_lookup_arb;

    localparam int NUM_REQ = 4;
    localparam int LIT_W   = 8;
    localparam int PTR_W   = 4;

    logic                     clk = 1'b0;
    logic                     rst_n;
    logic                     dummies_loaded;
    logic                     flush;
    logic [NUM_REQ-1:0]       req_valid;
    logic [NUM_REQ*LIT_W-1:0] req_lit;
    logic [NUM_REQ-1:0]       req_ready;
    logic [LIT_W-1:0]         clq_rqst_lit;
    logic                     clq_rqst_valid;
    logic [PTR_W-1:0]         clq_init_ptr;
    logic                     clq_init_ptr_valid;
    logic [NUM_REQ-1:0]       resp_valid;
    logic [NUM_REQ-1:0]       resp_ready;
    logic                     resp_hit;
    logic [PTR_W-1:0]         resp_ptr;
    logic                     busy;
    logic [15:0]              lookup_cnt;

    clq_lookup_arb #(.NUM_REQ(NUM_REQ), .LIT_W(LIT_W), .PTR_W(PTR_W)) dut (
        .clk(clk), .rst_n(rst_n), .dummies_loaded(dummies_loaded), .flush(flush),
        .req_valid(req_valid), .req_lit(req_lit), .req_ready(req_ready),
        .clq_rqst_lit(clq_rqst_lit), .clq_rqst_valid(clq_rqst_valid),
        .clq_init_ptr(clq_init_ptr), .clq_init_ptr_valid(clq_init_ptr_valid),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_hit(resp_hit),
        .resp_ptr(resp_ptr), .busy(busy), .lookup_cnt(lookup_cnt)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_err = 0;
    logic [15:0] exp_cnt = 16'd0;

    typedef struct {
        int          eng;
        logic [7:0]  lit;
        logic [3:0]  cptr;
        logic        cvld;
        logic        exp_hit;
        logic [3:0]  exp_ptr;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic bump_cnt();
        if (exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'd1;
    endtask

    // Single-engine transaction; entered and left in IDLE at a negedge.
    task automatic run_vec(input vec_t v);
        req_valid = 4'(1 << v.eng);
        req_lit   = '0;
        req_lit[v.eng*LIT_W +: LIT_W] = v.lit;
        clq_init_ptr       = v.cptr;
        clq_init_ptr_valid = v.cvld;
        resp_ready         = '0;
        #1;
        chk("accept", req_ready, 1 << v.eng);
        chk("idle_no_clq", clq_rqst_valid, 0);
        tick();
        req_valid = '0;
        #1;
        if (v.lit != 8'h00) begin
            chk("clq_valid", clq_rqst_valid, 1);
            chk("clq_lit", clq_rqst_lit, v.lit);
            chk("lookup_no_resp", resp_valid, 0);
            bump_cnt();
            tick();
            #1;
        end
        chk("resp_no_clq", clq_rqst_valid, 0);
        chk("resp_valid", resp_valid, 1 << v.eng);
        chk("resp_hit", resp_hit, v.exp_hit);
        chk("resp_ptr", resp_ptr, v.exp_ptr);
        chk("lookup_cnt", lookup_cnt, exp_cnt);
        resp_ready = 4'(1 << v.eng);
        tick();
        resp_ready = '0;
        #1;
        chk("resp_done", resp_valid, 0);
        chk("busy_idle", busy, 0);
    endtask

    initial begin
        vecs[0] = '{eng: 2, lit: 8'h05, cptr: 4'h7, cvld: 1'b1, exp_hit: 1'b1, exp_ptr: 4'h7};
        vecs[1] = '{eng: 1, lit: 8'hFD, cptr: 4'hA, cvld: 1'b0, exp_hit: 1'b0, exp_ptr: 4'h0};
        vecs[2] = '{eng: 0, lit: 8'h00, cptr: 4'h5, cvld: 1'b1, exp_hit: 1'b0, exp_ptr: 4'h0};
        vecs[3] = '{eng: 3, lit: 8'h81, cptr: 4'hF, cvld: 1'b1, exp_hit: 1'b1, exp_ptr: 4'hF};
        vecs[4] = '{eng: 3, lit: 8'h7F, cptr: 4'h0, cvld: 1'b1, exp_hit: 1'b1, exp_ptr: 4'h0};
        vecs[5] = '{eng: 0, lit: 8'h01, cptr: 4'h9, cvld: 1'b0, exp_hit: 1'b0, exp_ptr: 4'h0};

        rst_n = 1'b1; dummies_loaded = 1'b0; flush = 1'b0;
        req_valid = '0; req_lit = '0; resp_ready = '0;
        clq_init_ptr = '0; clq_init_ptr_valid = 1'b0;
        tick(); tick();
        chk("rst_req_ready", req_ready, 0);
        chk("rst_resp_valid", resp_valid, 0);
        chk("rst_clq_valid", clq_rqst_valid, 0);
        chk("rst_clq_lit", clq_rqst_lit, 0);
        chk("rst_resp_hit", resp_hit, 0);
        chk("rst_resp_ptr", resp_ptr, 0);
        chk("rst_busy", busy, 0);
        chk("rst_cnt", lookup_cnt, 0);
        rst_n = 1'b0;

        // All engines request before the dummy table is loaded.
        req_valid = 4'hF;
        req_lit   = 32'h44332211;
        resp_ready = 4'hF;
        clq_init_ptr = 4'h3; clq_init_ptr_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick(); #1;
            chk("wait_load_ready", req_ready, 0);
            chk("wait_load_busy", busy, 0);
        end
        dummies_loaded = 1'b1;
        #1 chk("load_cycle_ready", req_ready, 0);
        tick();
        dummies_loaded = 1'b0;

        // Round-robin order and 3-cycle spacing with resp_ready tied high.
        begin
            int last_cyc;
            last_cyc = 0;
            for (int k = 0; k < 5; k++) begin
                int t;
                t = 0;
                #1;
                while (req_ready == '0 && t < 10) begin
                    tick(); #1;
                    t++;
                end
                chk("rr_grant", req_ready, 1 << (k % 4));
                if (k > 0) chk("rr_spacing", cyc - last_cyc, 3);
                last_cyc = cyc;
                tick();
            end
        end
        req_valid = '0;
        tick(); tick();
        chk("rr_cnt", lookup_cnt, 5);
        chk("rr_busy", busy, 0);

        flush = 1'b1;
        tick();
        flush = 1'b0;
        exp_cnt = 16'd0;
        #1 chk("flush_idle_cnt", lookup_cnt, 0);
        dummies_loaded = 1'b1;
        tick();
        dummies_loaded = 1'b0;

        foreach (vecs[i]) run_vec(vecs[i]);

        // Held response with non-winner resp_ready bits high, then flush in RESP.
        req_valid = 4'b0010;
        req_lit   = 32'h00001200;
        clq_init_ptr = 4'h6; clq_init_ptr_valid = 1'b1;
        resp_ready = 4'b1101;
        #1 chk("hold_accept", req_ready, 4'b0010);
        tick();
        bump_cnt();
        req_valid = 4'b1001;
        req_lit   = 32'h34000056;
        tick();
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("hold_resp_valid", resp_valid, 4'b0010);
            chk("hold_resp_hit", resp_hit, 1);
            chk("hold_resp_ptr", resp_ptr, 4'h6);
            chk("hold_no_accept", req_ready, 0);
            tick();
        end
        flush = 1'b1;
        tick();
        flush = 1'b0;
        exp_cnt = 16'd0;
        #1;
        chk("flush_resp_valid", resp_valid, 0);
        chk("flush_busy", busy, 0);
        chk("flush_cnt", lookup_cnt, 0);
        chk("flush_wait_ready", req_ready, 0);

        // rr_last survives the flush: after engine 1, engine 3 beats engine 0.
        resp_ready = '0;
        dummies_loaded = 1'b1;
        tick();
        dummies_loaded = 1'b0;
        #1 chk("rr_kept_grant", req_ready, 4'b1000);
        tick();
        req_valid = '0;
        bump_cnt();
        tick();
        #1;
        chk("rr_kept_resp", resp_valid, 4'b1000);
        chk("rr_kept_cnt", lookup_cnt, exp_cnt);
        resp_ready = 4'b1000;
        tick();
        resp_ready = '0;

        // Saturation: preload the counter one short of the maximum.
        force dut.r_lookup_cnt = 16'hFFFE;
        tick();
        release dut.r_lookup_cnt;
        exp_cnt = 16'hFFFE;
        run_vec('{eng: 0, lit: 8'h21, cptr: 4'h2, cvld: 1'b1, exp_hit: 1'b1, exp_ptr: 4'h2});
        run_vec('{eng: 1, lit: 8'h22, cptr: 4'h4, cvld: 1'b1, exp_hit: 1'b1, exp_ptr: 4'h4});

        // Reset asserted mid-lookup returns everything to power-on values.
        req_valid = 4'b0001;
        req_lit   = 32'h00000022;
        tick();
        rst_n = 1'b1;
        tick();
        rst_n = 1'b0;
        #1;
        chk("mid_rst_resp_valid", resp_valid, 0);
        chk("mid_rst_clq_valid", clq_rqst_valid, 0);
        chk("mid_rst_cnt", lookup_cnt, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_ready", req_ready, 0);
        req_valid = '0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
